// File: rtl/elastic_pipeline_pkg.sv
// rtl/elastic_pipeline_pkg.sv - shared defaults and helpers for the elastic pipeline
// Optional occupancy counter is enabled by ELASTIC_PIPE_OCCUPANCY_EN.
package elastic_pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int STAGES_DEF = 5;

    // Counter width able to hold 0..2*stages beats.
    function automatic int cnt_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Beats held by one stage given its main/skid valids.
    function automatic logic [1:0] occupancy(input logic m_v, input logic s_v);
        return {1'b0, m_v} + {1'b0, s_v};
    endfunction

endpackage

// File: rtl/elastic_skid_stage.sv
// rtl/elastic_skid_stage.sv - one 2-entry skid stage with registered ready and flush
// With ELASTIC_PIPE_OCCUPANCY_EN the stage also reports its next-state occupancy.
module elastic_skid_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    input  logic              i_flush
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    output logic [1:0]        o_occ_next
`endif
);

    logic              m_v_q, m_v_d;
    logic              s_v_q, s_v_d;
    logic [DATA_W-1:0] m_d_q, m_d_d;
    logic [DATA_W-1:0] s_d_q, s_d_d;
    logic              in_ready_q;
    logic              push;
    logic              pop;

    assign push = i_in_valid & in_ready_q;
    assign pop  = m_v_q & i_out_ready;

    // Next-state: refill main from skid (or input) when it empties, park input in skid otherwise.
    always_comb begin
        m_v_d = m_v_q;
        m_d_d = m_d_q;
        s_v_d = s_v_q;
        s_d_d = s_d_q;
        if (pop || !m_v_q) begin
            if (s_v_q) begin
                m_v_d = 1'b1;
                m_d_d = s_d_q;
                s_v_d = 1'b0;
            end else begin
                m_v_d = push;
                if (push) begin
                    m_d_d = i_in_data;
                end
            end
        end else if (push) begin
            s_v_d = 1'b1;
            s_d_d = i_in_data;
        end
        // Flush kills whatever would sit here after the edge; the pop and push still complete.
        if (i_flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end
    end

    // State registers; ready is registered from next-state skid occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_v_q      <= 1'b0;
            s_v_q      <= 1'b0;
            m_d_q      <= '0;
            s_d_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            m_v_q      <= m_v_d;
            s_v_q      <= s_v_d;
            m_d_q      <= m_d_d;
            s_d_q      <= s_d_d;
            in_ready_q <= !s_v_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = m_v_q;
    assign o_out_data  = m_d_q;

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    assign o_occ_next = i_reset ? 2'd0 : occupancy(m_v_d, s_v_d);
`endif

endmodule

// File: rtl/elastic_pipeline.sv
// rtl/elastic_pipeline.sv - N-stage elastic pipeline of skid stages with per-stage flush
// Define ELASTIC_PIPE_OCCUPANCY_EN to add the registered o_count occupancy output.
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STAGES = STAGES_DEF
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    parameter int CNT_W  = cnt_width(STAGES)
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    input  logic              i_out_ready,
    input  logic [STAGES-1:0] i_flush_mask
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    output logic [CNT_W-1:0]  o_count
`endif
);

    // Link k connects stage k-1 to stage k; link 0 is the producer, link STAGES the consumer.
    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;
    logic [DATA_W-1:0] dat [0:STAGES];

    assign vld[0]      = i_in_valid;
    assign dat[0]      = i_in_data;
    assign o_in_ready  = rdy[0];
    assign rdy[STAGES] = i_out_ready;
    assign o_out_valid = vld[STAGES];
    assign o_out_data  = dat[STAGES];

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    logic [1:0] occ [0:STAGES-1];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        elastic_skid_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_in_valid  (vld[k]),
            .i_in_data   (dat[k]),
            .o_in_ready  (rdy[k]),
            .o_out_valid (vld[k+1]),
            .o_out_data  (dat[k+1]),
            .i_out_ready (rdy[k+1]),
            .i_flush     (i_flush_mask[k])
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
            ,
            .o_occ_next  (occ[k])
`endif
        );
    end

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    logic [CNT_W-1:0] count_d, count_q;

    // Sum next-state occupancy so the count equals beats held after the edge, flushes included.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            count_d = count_d + CNT_W'(occ[k]);
        end
    end

    // Registered occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb/tb_elastic_pipeline.sv - directed self-checking bench for elastic_pipeline
// Count checks are compiled in when ELASTIC_PIPE_OCCUPANCY_EN is defined.
module tb_elastic_pipeline;

    localparam int DW = 32;
    localparam int NS = 5;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_in_valid;
    logic [DW-1:0] i_in_data;
    logic          o_in_ready;
    logic          o_out_valid;
    logic [DW-1:0] o_out_data;
    logic          i_out_ready;
    logic [NS-1:0] i_flush_mask;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    localparam int CW = $clog2(2 * NS + 1);
    logic [CW-1:0] o_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] seen [$];

    always #5 i_clk = ~i_clk;

    elastic_pipeline #(
        .DATA_W (DW),
        .STAGES (NS)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .i_out_ready  (i_out_ready),
        .i_flush_mask (i_flush_mask)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        ,
        .o_count      (o_count)
`endif
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_in_valid   = 1'b0;
        i_in_data    = '0;
        i_out_ready  = 1'b0;
        i_flush_mask = '0;
    endtask

    // Stream beats base, base+1, ... with the consumer stalled; returns beats accepted.
    task automatic fill(input logic [DW-1:0] base, input int cycles, output int acc);
        acc = 0;
        i_out_ready = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            i_in_valid = 1'b1;
            i_in_data  = base + DW'(acc);
            if (o_in_ready) acc++;
            step();
        end
        i_in_valid = 1'b0;
    endtask

    // Let the pipe drain with the consumer ready, collecting delivered beats.
    task automatic drain(input int cycles);
        seen.delete();
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (o_out_valid) seen.push_back(o_out_data);
            step();
        end
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_reset = 1'b1;
        step();
        step();
        total++;
        if (o_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_in_ready got=%0b want=0", o_in_ready);
        end
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_out_valid got=%0b want=0", o_out_valid);
        end
        i_reset = 1'b0;
        step();
        total++;
        if (o_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%0b want=1", o_in_ready);
        end
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%0b want=0", o_out_valid);
        end
        total++;
        if (o_out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_out_data got=%h want=0", o_out_data);
        end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        total++;
        if (o_count !== CW'(0)) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", o_count);
        end
`endif
    endtask

    task automatic test_stream();
        int  sent = 0;
        int  got = 0;
        int  acc_cyc = -1;
        int  first_out = -1;
        int  cyc = 0;
        bit  gap = 1'b0;
        i_out_ready = 1'b1;
        while (got < 8 && cyc < 60) begin
            i_in_valid = (sent < 8);
            i_in_data  = DW'(sent + 1);
            if (i_in_valid && o_in_ready) begin
                if (sent == 0) acc_cyc = cyc;
                sent++;
            end
            if (o_out_valid) begin
                if (first_out < 0) first_out = cyc;
                total++;
                if (o_out_data !== DW'(got + 1)) begin
                    bad++;
                    $display("FAIL stream_data got=%h want=%h", o_out_data, DW'(got + 1));
                end
                got++;
            end else if (first_out >= 0) begin
                gap = 1'b1;
            end
            step();
            cyc++;
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        total++;
        if (got != 8) begin
            bad++;
            $display("FAIL stream_count got=%0d want=8", got);
        end
        total++;
        if (first_out - acc_cyc != NS) begin
            bad++;
            $display("FAIL stream_latency got=%0d want=%0d", first_out - acc_cyc, NS);
        end
        total++;
        if (gap) begin
            bad++;
            $display("FAIL stream_gap got=1 want=0");
        end
    endtask

    task automatic test_backpressure();
        int acc;
        fill(32'h10, 30, acc);
        total++;
        if (acc != 2 * NS) begin
            bad++;
            $display("FAIL bp_accepted got=%0d want=%0d", acc, 2 * NS);
        end
        total++;
        if (o_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_in_ready got=%0b want=0", o_in_ready);
        end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        total++;
        if (o_count !== CW'(10)) begin
            bad++;
            $display("FAIL bp_count got=%0d want=10", o_count);
        end
`endif
        drain(40);
        total++;
        if (seen.size() != 10) begin
            bad++;
            $display("FAIL bp_drain_size got=%0d want=10", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 10; i++) begin
            total++;
            if (seen[i] !== 32'h10 + DW'(i)) begin
                bad++;
                $display("FAIL bp_drain_data idx=%0d got=%h want=%h", i, seen[i], 32'h10 + DW'(i));
            end
        end
    endtask

    task automatic test_flush_mid();
        int acc;
        logic [DW-1:0] exp_q [8] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h26, 32'h27, 32'h28, 32'h29};
        fill(32'h20, 30, acc);
        i_flush_mask = 5'b00100;
        step();
        i_flush_mask = '0;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        total++;
        if (o_count !== CW'(8)) begin
            bad++;
            $display("FAIL flush2_count got=%0d want=8", o_count);
        end
`endif
        drain(40);
        total++;
        if (seen.size() != 8) begin
            bad++;
            $display("FAIL flush2_size got=%0d want=8", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 8; i++) begin
            total++;
            if (seen[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL flush2_data idx=%0d got=%h want=%h", i, seen[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush_out();
        logic [DW-1:0] beats [3] = '{32'hA, 32'hB, 32'hC};
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = beats[i];
            step();
        end
        i_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        total++;
        if (o_out_valid !== 1'b1 || o_out_data !== 32'hA) begin
            bad++;
            $display("FAIL flush4_head got=%0b/%h want=1/%h", o_out_valid, o_out_data, 32'hA);
        end
        i_out_ready  = 1'b1;
        i_flush_mask = 5'b10000;
        step();
        i_flush_mask = '0;
        i_out_ready  = 1'b0;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        total++;
        if (o_count !== CW'(1)) begin
            bad++;
            $display("FAIL flush4_count got=%0d want=1", o_count);
        end
`endif
        drain(20);
        total++;
        if (seen.size() != 1) begin
            bad++;
            $display("FAIL flush4_size got=%0d want=1", seen.size());
        end else if (seen[0] !== 32'hC) begin
            total++;
            bad++;
            $display("FAIL flush4_survivor got=%h want=%h", seen[0], 32'hC);
        end
    endtask

    task automatic test_flush_in();
        i_out_ready  = 1'b1;
        i_in_valid   = 1'b1;
        i_in_data    = 32'hDEAD;
        i_flush_mask = 5'b00001;
        total++;
        if (o_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush0_handshake got=%0b want=1", o_in_ready);
        end
        step();
        i_flush_mask = '0;
        i_in_data    = 32'h77;
        step();
        i_in_valid = 1'b0;
        drain(20);
        total++;
        if (seen.size() != 1) begin
            bad++;
            $display("FAIL flush0_size got=%0d want=1", seen.size());
        end else if (seen[0] !== 32'h77) begin
            total++;
            bad++;
            $display("FAIL flush0_data got=%h want=%h", seen[0], 32'h77);
        end
    endtask

    task automatic test_reset_mid();
        int first_out = -1;
        int outs = 0;
        logic [DW-1:0] last = '0;
        i_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = 32'h60 + DW'(i);
            step();
        end
        i_reset = 1'b1;
        step();
        total++;
        if (o_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_hold_out_valid got=%0b want=0", o_out_valid);
        end
        i_reset    = 1'b0;
        i_in_valid = 1'b0;
        step();
        total++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_out_data !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_state got=%0b/%0b/%h want=1/0/0", o_in_ready, o_out_valid, o_out_data);
        end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        total++;
        if (o_count !== CW'(0)) begin
            bad++;
            $display("FAIL rstmid_count got=%0d want=0", o_count);
        end
`endif
        i_in_valid = 1'b1;
        i_in_data  = 32'h55;
        step();
        i_in_valid = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (o_out_valid) begin
                if (first_out < 0) first_out = c;
                outs++;
                last = o_out_data;
            end
            step();
        end
        i_out_ready = 1'b0;
        total++;
        if (outs != 1 || last !== 32'h55) begin
            bad++;
            $display("FAIL rstmid_beat got=%0d/%h want=1/%h", outs, last, 32'h55);
        end
        total++;
        if (first_out != NS) begin
            bad++;
            $display("FAIL rstmid_latency got=%0d want=%0d", first_out, NS);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_mid();
        test_flush_out();
        test_flush_in();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
